if_queue: RTL and testbench
===========================

IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter XLEN, default 32, address and PC width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, instruction-queue entries and credit limit; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_req_addr  out  XLEN  fetch address; equals fetch_PC.
REQ-009 imem_resp_valid  in  1  in-order instruction response.
REQ-010 imem_resp_data  in  32  instruction word.
REQ-011 redirect  in  1  jump or branch taken; flush and restart.
REQ-012 redirect_pc  in  XLEN  restart address.
REQ-013 halt  in  1  stop issuing new requests, for example on the simulation-stop condition.
REQ-014 out_valid  out  1  queue head valid.
REQ-015 out_ready  in  1  decode stage accepts head.
REQ-016 out_inst  out  32  head instruction.
REQ-017 out_pc  out  XLEN  head instruction PC.
REQ-018 fetch_PC  out  XLEN  next address to request.

Function
REQ-019 Request fire is imem_req_valid and imem_req_ready; response fire is imem_resp_valid; pop is out_valid and out_ready.
REQ-020 State: fetch_PC, resp_pc, outstanding count (0..DEPTH), drop count (0..DEPTH), and a DEPTH-entry FIFO of {inst, pc} with head pointer, tail pointer and count.
REQ-021 imem_req_valid is 1 iff all of the following hold:
- not rst, not halt and not redirect;
- outstanding + count < DEPTH.
REQ-022 imem_req_valid, once asserted, is not required to hold. Memory samples the address only on fire.
REQ-023 On request fire: fetch_PC <= fetch_PC + 4, wrapping modulo 2^XLEN, and outstanding increments.
REQ-024 On response fire, outstanding decrements. Request and response fire in the same cycle leave outstanding unchanged.
REQ-025 Response fire with drop > 0 discards the word and decrements drop; nothing is pushed and resp_pc is unchanged.
REQ-026 Response fire with drop = 0 pushes {imem_resp_data, resp_pc} at the tail, and resp_pc <= resp_pc + 4.
REQ-027 Latency: a response accepted in cycle N is presented on out_valid/out_inst in cycle N+1 when the queue was empty.
REQ-028 Same-cycle push and pop are both performed and count is unchanged. A push into a full queue cannot occur, by construction of the credit rule in REQ-021.
REQ-029 out_valid is 1 iff count > 0. out_inst and out_pc come from the head entry and are held stable while out_valid is 1 and out_ready is 0.
REQ-030 On redirect, the flush has priority over every other event in that cycle:
- the FIFO is cleared (count 0, pointers 0) and any pop that cycle is ignored;
- any response that cycle is discarded;
- fetch_PC <= {redirect_pc[XLEN-1:2], 2'b00} and resp_pc <= the same value;
- outstanding <= outstanding - imem_resp_valid, and drop <= that same next outstanding value;
- no request issues that cycle.
REQ-031 Back-to-back redirects: each redirect re-applies REQ-030, and the last redirect's PC wins.
REQ-032 halt: requests stop from the same cycle. In-flight responses still complete, pushes and pops continue, and a redirect is still honoured. Deasserting halt resumes from fetch_PC.
REQ-033 Full: outstanding + count = DEPTH deasserts imem_req_valid until a pop or a dropped response frees a credit.

Reset
REQ-034 Reset state while rst is high, and in the first cycle after it falls:
- fetch_PC = RESET_PC, resp_pc = RESET_PC;
- outstanding = 0, drop = 0, FIFO empty;
- out_valid = 0, imem_req_valid = 0 during rst.
REQ-035 Reset mid-operation discards all queued and in-flight state. The instruction memory is reset by the same rst, so no response for a pre-reset request arrives after rst falls.
REQ-036 The first request after rst falls is issued in the next cycle, with address RESET_PC.

Verification
REQ-037 Streaming: memory always ready with 1-cycle response, out_ready = 1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008, ... with one instruction per cycle and no gaps after the first.
REQ-038 Backpressure: DEPTH = 4, out_ready = 0 -> exactly 4 requests fire, imem_req_valid then stays 0, and out_pc holds 0x80000000. Raising out_ready for 1 cycle -> exactly 1 further request.
REQ-039 Redirect with 2 outstanding: redirect_pc = 0x80000103 -> next imem_req_addr = 0x80000100, the next 2 responses are dropped, and the first out_pc after the flush is 0x80000100.
REQ-040 Simultaneous events: push and pop in the same cycle keep count constant; redirect in the same cycle as a response and a pop -> queue empty and the response discarded.
REQ-041 halt asserted with 3 outstanding -> 0 new requests, all 3 instructions delivered in order. halt released -> requests resume at the held fetch_PC.
REQ-042 Reset mid-stream with queue full -> out_valid = 0 in the next cycle, and the next imem_req_addr = 0x80000000.

Source files
------------

// File: rtl/if_queue.sv
// if_queue: instruction fetch front end with an in-order instruction queue.
//
// Fetch requests are credited so that requests in flight plus queued
// instructions never exceed DEPTH, which means a response can always be
// pushed. A redirect flushes the queue and marks every request still in
// flight as stale. Stale responses are dropped by counting them down.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   imem_req_*       fetch request (valid/ready handshake, address = fetch_PC)
//   imem_resp_*      in-order instruction responses (no backpressure)
//   redirect(_pc)    flush and restart fetch at redirect_pc (word aligned)
//   halt             suppress new requests; in-flight work still drains
//   out_*            queue head to decode (valid/ready handshake)
//   fetch_PC         next address to request
module if_queue #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000,
  parameter int               DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] fetch_PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count, outstanding, drop;
  logic [XLEN-1:0] fetch_pc_q, resp_pc;

  logic            req_fire, push, pop;
  logic [CW:0]     used;
  logic [CW-1:0]   flush_outstanding;
  logic [XLEN-1:0] redirect_base;
  logic            unused_redirect_lsbs;

  assign used          = {1'b0, outstanding} + {1'b0, count};
  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit rule: in-flight + queued never exceeds DEPTH, so push never overflows.
  assign imem_req_valid = !rst && !halt && !redirect && (used < DEPTH_L);
  assign imem_req_addr  = fetch_pc_q;
  assign fetch_PC       = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Redirect wins over push and pop in the same cycle.
  assign push = imem_resp_valid && !redirect && (drop == '0);
  assign pop  = (count != '0) && out_ready && !redirect;

  // A response arriving alongside a redirect retires one in-flight request;
  // everything still in flight afterwards is stale.
  assign flush_outstanding = outstanding - CW'(imem_resp_valid);

  assign out_valid = (count != '0);
  assign out_inst  = mem[head].inst;
  assign out_pc    = mem[head].pc;

  // Storage has no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[tail] <= '{inst: imem_resp_data, pc: resp_pc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc_q  <= redirect_base;
      resp_pc     <= redirect_base;
      outstanding <= flush_outstanding;
      drop        <= flush_outstanding;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (req_fire)
        fetch_pc_q <= fetch_pc_q + PC_INC;

      if (req_fire && !imem_resp_valid)
        outstanding <= outstanding + CW'(1);
      else if (!req_fire && imem_resp_valid)
        outstanding <= outstanding - CW'(1);

      if (imem_resp_valid && (drop != '0))
        drop <= drop - CW'(1);

      if (push) begin
        tail    <= tail + AW'(1);
        resp_pc <= resp_pc + PC_INC;
      end
      if (pop)
        head <= head + AW'(1);

      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// Randomized bench for if_queue. The reference keeps the in-flight requests
// as a list of {addr, stale} and the expected queue as a list of {inst, pc};
// the memory model answers in order with a word derived from the address.
module tb_if_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam int          NCYC  = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect, halt;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid, out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc, fetch_PC;

  if_queue #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .fetch_PC(fetch_PC)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } fl_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  fl_t  infl[$];
  ent_t fq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  initial begin
    logic [31:0] efpc;
    bit          exp_rv, pop_e, have_r, halt_st;
    fl_t         r;
    int          ph;

    efpc = RPC; halt_st = 0;
    rst = 1; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    redirect = 0; redirect_pc = '0; halt = 0; out_ready = 0;
    @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      ph = (cyc / 300) % 5;
      // phase 0 streaming, 1 backpressure, 2 redirect-heavy, 3 halt, 4 mixed
      rst = (cyc < 2) || (cyc % 300 == 0 && ph == 2) ||
            (ph == 4 && $urandom_range(0, 99) == 0);
      imem_req_ready = (ph == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      imem_resp_valid = !rst && infl.size() > 0 && (ph == 0 || $urandom_range(0, 2) != 0);
      imem_resp_data  = imem_resp_valid ? word_of(infl[0].addr) : $urandom;
      out_ready = (ph == 0) ? 1'b1 : (ph == 1) ? ($urandom_range(0, 7) == 0)
                                               : ($urandom_range(0, 1) == 1);
      redirect = !rst && ((ph == 2 && $urandom_range(0, 5) == 0) ||
                          (ph >= 3 && $urandom_range(0, 19) == 0));
      redirect_pc = (ph == 4) ? $urandom : (RPC | $urandom_range(0, 1023));
      if (ph == 3 && $urandom_range(0, 9) == 0) halt_st = !halt_st;
      else if (ph == 4 && $urandom_range(0, 19) == 0) halt_st = !halt_st;
      else if (ph < 3) halt_st = 0;
      halt = halt_st;
      #1;

      exp_rv = !rst && !halt && !redirect && (infl.size() + fq.size() < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      chk("fetch_pc", fetch_PC, efpc);
      chk("req_addr", imem_req_addr, efpc);
      chk("out_valid", out_valid, fq.size() > 0);
      if (fq.size() > 0) begin
        chk("out_pc", out_pc, fq[0].pc);
        chk("out_inst", out_inst, fq[0].inst);
      end

      if (rst) begin
        infl.delete(); fq.delete(); efpc = RPC;
      end else begin
        pop_e  = fq.size() > 0 && out_ready;
        have_r = imem_resp_valid;
        if (have_r) r = infl.pop_front();
        if (redirect) begin
          fq.delete();
          foreach (infl[i]) infl[i].stale = 1;
          efpc = {redirect_pc[31:2], 2'b00};
        end else begin
          if (pop_e) fq.delete(0);
          if (have_r && !r.stale) fq.push_back('{word_of(r.addr), r.addr});
          if (exp_rv && imem_req_ready) begin
            infl.push_back('{efpc, 1'b0});
            efpc = efpc + 32'd4;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
